// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 burst memory slave bus: AW/W/B write and AR/R read channels.
// Master drives addresses, write data and response readies; slave drives the rest.
interface axi4_burst_mem_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [BYTES-1:0]  WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWLEN, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        output ARADDR, ARLEN, ARBURST, ARVALID,
        output RREADY,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWADDR, AWLEN, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARBURST, ARVALID,
        input  RREADY,
        output AWREADY, WREADY, BRESP, BVALID,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave: FIXED/INCR/WRAP bursts, byte strobes, range checks.
// Serves one write or read burst at a time from an internal word RAM.
module axi4_burst_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input logic                    ACLK,
    input logic                    ARESETN,
    axi4_burst_mem_slave_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

    state_t            state_q, state_d;
    logic              prio_wr_q, prio_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        burst_q, burst_d;
    logic              berr_q, berr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              rvalid_q, rvalid_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic              sel_wr;
    logic              aw_bad;
    logic              ar_bad;
    logic [1:0]        ar_eff;

    function automatic logic bad_burst(input logic [1:0] b, input logic [7:0] l);
        logic wrap_ok;
        wrap_ok = (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
        return (b == 2'b11) || ((b == 2'b10) && !wrap_ok);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] b,
                                                    input logic [7:0] l);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] m;
        inc = a + ADDR_W'(BYTES);
        m = ((ADDR_W'(l) + ADDR_W'(1)) << OFF_W) - ADDR_W'(1);
        unique case (b)
            2'b00:   return a;
            2'b10:   return (a & ~m) | (inc & m);
            default: return inc;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < LIMIT;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    assign aw_bad = bad_burst(bus.AWBURST, bus.AWLEN);
    assign ar_bad = bad_burst(bus.ARBURST, bus.ARLEN);
    assign ar_eff = ar_bad ? 2'b01 : bus.ARBURST;
    assign sel_wr = bus.AWVALID && (!bus.ARVALID || prio_wr_q);

    assign bus.BVALID = (state_q == S_WRESP);
    assign bus.BRESP  = ((state_q == S_WRESP) && err_q) ? 2'b10 : 2'b00;
    assign bus.RVALID = rvalid_q;
    assign bus.RDATA  = rdata_q;
    assign bus.RRESP  = rresp_q;
    assign bus.RLAST  = rlast_q;

    // Next-state, handshake readies and read-beat loading
    always_comb begin
        state_d     = state_q;
        prio_wr_d   = prio_wr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        berr_d      = berr_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rvalid_d    = rvalid_q;
        mem_we      = 1'b0;
        bus.AWREADY = 1'b0;
        bus.ARREADY = 1'b0;
        bus.WREADY  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.AWREADY = ARESETN && sel_wr;
                bus.ARREADY = ARESETN && bus.ARVALID && !sel_wr;
                if (bus.AWVALID && bus.ARVALID) begin
                    prio_wr_d = !sel_wr;
                end
                if (sel_wr) begin
                    addr_d  = bus.AWADDR;
                    len_d   = bus.AWLEN;
                    burst_d = aw_bad ? 2'b01 : bus.AWBURST;
                    berr_d  = aw_bad;
                    err_d   = aw_bad;
                    cnt_d   = 8'd0;
                    state_d = S_WDATA;
                end else if (bus.ARVALID) begin
                    len_d    = bus.ARLEN;
                    burst_d  = ar_eff;
                    berr_d   = ar_bad;
                    cnt_d    = 8'd0;
                    rvalid_d = 1'b1;
                    rlast_d  = (bus.ARLEN == 8'd0);
                    rdata_d  = '0;
                    rresp_d  = 2'b10;
                    if (!ar_bad && in_range(bus.ARADDR)) begin
                        rdata_d = mem[idx(bus.ARADDR)];
                        rresp_d = 2'b00;
                    end
                    addr_d  = next_addr(bus.ARADDR, ar_eff, bus.ARLEN);
                    state_d = S_RDATA;
                end
            end
            S_WDATA: begin
                bus.WREADY = 1'b1;
                if (bus.WVALID) begin
                    mem_we = !berr_q && in_range(addr_q);
                    err_d  = err_q || berr_q || !in_range(addr_q) ||
                             (bus.WLAST != (cnt_q == len_q));
                    addr_d = next_addr(addr_q, burst_q, len_q);
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        state_d = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                if (bus.BREADY) begin
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (bus.RREADY) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rdata_d  = '0;
                        rresp_d  = 2'b00;
                        state_d  = S_IDLE;
                    end else begin
                        rdata_d = '0;
                        rresp_d = 2'b10;
                        if (!berr_q && in_range(addr_q)) begin
                            rdata_d = mem[idx(addr_q)];
                            rresp_d = 2'b00;
                        end
                        addr_d  = next_addr(addr_q, burst_q, len_q);
                        cnt_d   = cnt_q + 8'd1;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            prio_wr_q <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            berr_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            berr_q    <= berr_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Strobed RAM write; contents are never reset
    always_ff @(posedge ACLK) begin
        if (ARESETN && mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.WSTRB[b]) begin
                    mem[idx(addr_q)][8*b +: 8] <= bus.WDATA[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: vector table plus hand-written
// sequences for arbitration, wrap, stalls, range errors, WLAST and reset.
module tb_axi4_burst_mem_slave;
    logic ACLK = 1'b0;
    logic ARESETN;

    always #5 ACLK = ~ACLK;

    axi4_burst_mem_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    axi4_burst_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [3:0]  strb;
        logic [31:0] d;
        bit          step;
        logic [1:0]  resp;
    } vec_t;

    vec_t        tbl[15];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] wd[16];
    logic [31:0] rd[16];
    logic [1:0]  rr[16];
    logic        rl[16];
    logic [1:0]  bresp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout", nm);
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [7:0] len,
                               input logic [1:0] b, input logic [3:0] s,
                               input int last_at);
        int n;
        bresp = 2'bxx;
        bus.AWADDR = a; bus.AWLEN = len; bus.AWBURST = b; bus.AWVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!bus.AWREADY && n < 64);
        if (!bus.AWREADY) begin tmo("aw_ready"); bus.AWVALID = 1'b0; return; end
        @(posedge ACLK); #1 bus.AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.WVALID = 1'b1; bus.WDATA = wd[i]; bus.WSTRB = s;
            bus.WLAST = (i == last_at);
            n = 0;
            do begin @(negedge ACLK); n++; end while (!bus.WREADY && n < 64);
            if (!bus.WREADY) begin tmo("w_ready"); bus.WVALID = 1'b0; return; end
            @(posedge ACLK); #1;
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!bus.BVALID && n < 64);
        if (!bus.BVALID) begin tmo("b_valid"); bus.BREADY = 1'b0; return; end
        bresp = bus.BRESP;
        @(posedge ACLK); #1 bus.BREADY = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] a, input logic [7:0] len,
                              input logic [1:0] b, input bit stall);
        int          n;
        int          got;
        int          cyc;
        bit          hold;
        logic [31:0] held;
        logic        held_last;
        for (int i = 0; i < 16; i++) begin rd[i] = 'x; rr[i] = 'x; rl[i] = 1'bx; end
        bus.ARADDR = a; bus.ARLEN = len; bus.ARBURST = b; bus.ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!bus.ARREADY && n < 64);
        if (!bus.ARREADY) begin tmo("ar_ready"); bus.ARVALID = 1'b0; return; end
        @(posedge ACLK); #1 bus.ARVALID = 1'b0;
        bus.RREADY = !stall;
        got = 0; cyc = 0; hold = 0; held = '0; held_last = 1'b0; n = 0;
        while (got <= int'(len) && n < 200) begin
            @(negedge ACLK);
            if (bus.RVALID) begin
                if (hold) begin
                    chk("rdata_stable", bus.RDATA, held);
                    chk("rlast_stable", 32'(bus.RLAST), 32'(held_last));
                end
                if (bus.RREADY) begin
                    rd[got] = bus.RDATA; rr[got] = bus.RRESP; rl[got] = bus.RLAST;
                    got++;
                    hold = 0;
                end else begin
                    hold = 1; held = bus.RDATA; held_last = bus.RLAST;
                end
            end
            @(posedge ACLK); #1;
            cyc++; n++;
            if (stall) bus.RREADY = cyc[0];
        end
        if (got <= int'(len)) tmo("r_beats");
        bus.RREADY = 1'b0;
    endtask

    initial begin
        int got;
        int n;
        tbl[0]  = '{"incr_wr",   1, 32'h04C, 8'd8, 2'b01, 4'hF, 32'hFFFF0000, 1, 2'b00};
        tbl[1]  = '{"incr_rd",   0, 32'h04C, 8'd8, 2'b01, 4'hF, 32'hFFFF0000, 1, 2'b00};
        tbl[2]  = '{"prefill",   1, 32'h07C, 8'd0, 2'b01, 4'hF, 32'hFFFFFFFF, 0, 2'b00};
        tbl[3]  = '{"strb_wr",   1, 32'h07C, 8'd0, 2'b01, 4'h3, 32'h12345678, 0, 2'b00};
        tbl[4]  = '{"strb_rd",   0, 32'h07C, 8'd0, 2'b01, 4'hF, 32'hFFFF5678, 0, 2'b00};
        tbl[5]  = '{"fill200",   1, 32'h200, 8'd0, 2'b01, 4'hF, 32'h11111111, 0, 2'b00};
        tbl[6]  = '{"rsvd_wr",   1, 32'h200, 8'd0, 2'b11, 4'hF, 32'hDEADBEEF, 0, 2'b10};
        tbl[7]  = '{"rsvd_chk",  0, 32'h200, 8'd0, 2'b01, 4'hF, 32'h11111111, 0, 2'b00};
        tbl[8]  = '{"rsvd_rd",   0, 32'h200, 8'd1, 2'b11, 4'hF, 32'h00000000, 0, 2'b10};
        tbl[9]  = '{"fill240",   1, 32'h240, 8'd2, 2'b01, 4'hF, 32'h66660000, 1, 2'b00};
        tbl[10] = '{"badwrap_w", 1, 32'h240, 8'd2, 2'b10, 4'hF, 32'h77770000, 1, 2'b10};
        tbl[11] = '{"badwrap_c", 0, 32'h240, 8'd2, 2'b01, 4'hF, 32'h66660000, 1, 2'b00};
        tbl[12] = '{"badwrap_r", 0, 32'h240, 8'd2, 2'b10, 4'hF, 32'h00000000, 0, 2'b10};
        tbl[13] = '{"fixed_wr",  1, 32'h300, 8'd2, 2'b00, 4'hF, 32'h88880000, 1, 2'b00};
        tbl[14] = '{"fixed_chk", 0, 32'h300, 8'd0, 2'b01, 4'hF, 32'h88880002, 0, 2'b00};

        bus.AWADDR = '0; bus.AWLEN = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", 32'(bus.AWREADY), 0);
        chk("rst_arready", 32'(bus.ARREADY), 0);
        chk("rst_wready",  32'(bus.WREADY), 0);
        chk("rst_bvalid",  32'(bus.BVALID), 0);
        chk("rst_rvalid",  32'(bus.RVALID), 0);
        chk("rst_rdata",   bus.RDATA, 0);
        chk("rst_resp",    32'({bus.BRESP, bus.RRESP, bus.RLAST}), 0);
        @(posedge ACLK); #1 ARESETN = 1'b1;

        // First contest: write wins, then read wins the next one
        bus.AWADDR = 32'h100; bus.AWLEN = 8'd0; bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        bus.ARADDR = 32'h100; bus.ARLEN = 8'd0; bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
        bus.WDATA = 32'h55AA55AA; bus.WSTRB = 4'hF; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        @(negedge ACLK);
        chk("arb1_aw", 32'(bus.AWREADY), 1);
        chk("arb1_ar", 32'(bus.ARREADY), 0);
        @(posedge ACLK); @(negedge ACLK);
        chk("arb_wready", 32'(bus.WREADY), 1);
        @(posedge ACLK); @(negedge ACLK);
        chk("arb_bvalid", 32'(bus.BVALID), 1);
        chk("arb_bresp", 32'(bus.BRESP), 0);
        @(posedge ACLK); @(negedge ACLK);
        chk("arb2_ar", 32'(bus.ARREADY), 1);
        chk("arb2_aw", 32'(bus.AWREADY), 0);
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.ARVALID = 1'b0; bus.WVALID = 1'b0;
        bus.WLAST = 1'b0; bus.BREADY = 1'b0;
        @(negedge ACLK);
        chk("arb_rvalid", 32'(bus.RVALID), 1);
        chk("arb_rdata", bus.RDATA, 32'h55AA55AA);
        chk("arb_rlast", 32'(bus.RLAST), 1);
        @(posedge ACLK); #1 bus.RREADY = 1'b0;

        for (int k = 0; k < 15; k++) begin
            if (tbl[k].wr) begin
                for (int i = 0; i < 16; i++) wd[i] = tbl[k].d + 32'(i);
                write_burst(tbl[k].addr, tbl[k].len, tbl[k].burst, tbl[k].strb,
                            int'(tbl[k].len));
                chk($sformatf("%s_bresp", tbl[k].name), 32'(bresp), 32'(tbl[k].resp));
            end else begin
                read_burst(tbl[k].addr, tbl[k].len, tbl[k].burst, 0);
                for (int i = 0; i <= int'(tbl[k].len); i++) begin
                    chk($sformatf("%s_d%0d", tbl[k].name, i), rd[i],
                        tbl[k].d + (tbl[k].step ? 32'(i) : 32'd0));
                    chk($sformatf("%s_r%0d", tbl[k].name, i), 32'(rr[i]), 32'(tbl[k].resp));
                    chk($sformatf("%s_l%0d", tbl[k].name, i), 32'(rl[i]),
                        32'(i == int'(tbl[k].len)));
                end
            end
        end

        // WRAP write lands at 38,3C,30,34
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
        write_burst(32'h38, 8'd3, 2'b10, 4'hF, 3);
        chk("wrap_bresp", 32'(bresp), 0);
        read_burst(32'h30, 8'd3, 2'b01, 0);
        chk("wrap_d0", rd[0], 32'hA2);
        chk("wrap_d1", rd[1], 32'hA3);
        chk("wrap_d2", rd[2], 32'hA0);
        chk("wrap_d3", rd[3], 32'hA1);

        // FIXED read with RREADY toggling
        read_burst(32'h7C, 8'd3, 2'b00, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fixed_d%0d", i), rd[i], 32'hFFFF5678);
            chk($sformatf("fixed_l%0d", i), 32'(rl[i]), 32'(i == 3));
        end

        // Burst running off the top of memory
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002;
        write_burst(32'h3FC, 8'd1, 2'b01, 4'hF, 1);
        chk("oor_bresp", 32'(bresp), 2);
        read_burst(32'h3FC, 8'd1, 2'b01, 0);
        chk("oor_d0", rd[0], 32'hCAFE0001);
        chk("oor_r0", 32'(rr[0]), 0);
        chk("oor_d1", rd[1], 0);
        chk("oor_r1", 32'(rr[1]), 2);

        // Early WLAST: still four beats, data written, SLVERR
        for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + 32'(i);
        write_burst(32'h10, 8'd3, 2'b01, 4'hF, 0);
        chk("wlast_bresp", 32'(bresp), 2);
        read_burst(32'h10, 8'd3, 2'b01, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wlast_d%0d", i), rd[i], 32'hB0 + 32'(i));
            chk($sformatf("wlast_r%0d", i), 32'(rr[i]), 0);
        end

        // Reset during beat 3 of an 8-beat read
        bus.ARADDR = 32'h4C; bus.ARLEN = 8'd7; bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!bus.ARREADY && n < 64);
        if (!bus.ARREADY) tmo("rst_ar_ready");
        @(posedge ACLK); #1 bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
        got = 0; n = 0;
        while (got < 3 && n < 64) begin
            @(negedge ACLK);
            if (bus.RVALID) got++;
            @(posedge ACLK); #1;
            n++;
        end
        if (got < 3) tmo("rst_beats");
        @(negedge ACLK);
        chk("midrst_beat3", bus.RDATA, 32'hFFFF0003);
        ARESETN = 1'b0;
        @(posedge ACLK); #1 ARESETN = 1'b1; bus.RREADY = 1'b0;
        @(negedge ACLK);
        chk("midrst_rvalid", 32'(bus.RVALID), 0);
        chk("midrst_rdata", bus.RDATA, 0);
        chk("midrst_rlast", 32'(bus.RLAST), 0);
        bus.AWVALID = 1'b1; bus.ARVALID = 1'b1;
        #1;
        chk("midrst_idle_aw", 32'(bus.AWREADY), 1);
        chk("midrst_idle_ar", 32'(bus.ARREADY), 0);
        bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
        @(posedge ACLK); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
